dm_mmio_responder: RTL and testbench

//  Responder for the pipeline's data-memory port. It sits between the core's data-port signals
//  (D_ADDR/D_OUT/D_IN/dm_wen/dm_oen) and the RAM2Kx32 DM macro.
//  It passes RAM accesses through and serves a 16-word memory-mapped register window:
//  64-bit cycle counter, scratch register, console TX FIFO and halt/exit-code register.
//  D_IN read timing is identical to the RAM: data appears the cycle after the address.

---
 rtl/dm_mmio_pkg.sv | 27 ++
 rtl/dm_mmio_responder_tx_fifo.sv | 50 +++++
 rtl/dm_mmio_responder.sv | 121 ++++++++++++
 tb/tb_dm_mmio_responder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_mmio_pkg.sv
// Shared register offsets and status-bit layout for the data-memory MMIO responder.
package dm_mmio_pkg;

    localparam logic [3:0] REG_CYCLE_LO = 4'd0;
    localparam logic [3:0] REG_CYCLE_HI = 4'd1;
    localparam logic [3:0] REG_TX_DATA  = 4'd2;
    localparam logic [3:0] REG_TX_STAT  = 4'd3;
    localparam logic [3:0] REG_SCRATCH  = 4'd4;
    localparam logic [3:0] REG_HALT     = 4'd5;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 4;

    function automatic logic [7:0] tx_stat_pack(input logic full, input logic empty,
                                                input logic ovf, input logic [3:0] count);
        logic [7:0] s;
        s = '0;
        s[STAT_FULL]                   = full;
        s[STAT_EMPTY]                  = empty;
        s[STAT_OVF]                    = ovf;
        s[STAT_CNT_LSB +: 4]           = count;
        return s;
    endfunction

endpackage

// File: rtl/dm_mmio_responder_tx_fifo.sv
// Synchronous console TX FIFO; a push while full is accepted only if a pop frees a slot.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/dm_mmio_responder.sv
// Data-port responder: RAM passthrough plus a 16-word MMIO window (cycle counter,
// scratch, console TX FIFO, halt/exit code) with RAM-identical one-cycle read latency.
module dm_mmio_responder
    import dm_mmio_pkg::*;
#(
    parameter int                ADDR_W     = 11,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] MMIO_BASE  = 11'h7F0,
    parameter int                FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_OUT,
    input  logic              dm_wen,
    input  logic              dm_oen,
    output logic [DATA_W-1:0] D_IN,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_wen,
    output logic              ram_oen,
    input  logic [DATA_W-1:0] ram_q,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              halt,
    output logic [7:0]        exit_code
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              mmio_hit;
    logic [3:0]        off;
    logic              rd;
    logic              wr;
    logic [63:0]       cycle_cnt;
    logic [31:0]       hi_shadow;
    logic [DATA_W-1:0] scratch;
    logic              ovf;
    logic              sel_q;
    logic [DATA_W-1:0] mmio_q;
    logic [DATA_W-1:0] rd_data;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    assign mmio_hit = (D_ADDR[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
    assign off      = D_ADDR[3:0];
    assign rd       = !dm_oen;
    assign wr       = !dm_wen && mmio_hit;

    assign ram_a    = D_ADDR;
    assign ram_d    = D_OUT;
    assign ram_oen  = dm_oen;
    assign ram_wen  = dm_wen | mmio_hit;

    assign tx_valid = !fifo_empty;
    assign pop      = tx_valid && tx_ready;
    assign push     = wr && (off == REG_TX_DATA);
    assign D_IN     = sel_q ? mmio_q : ram_q;

    // NOTE: default first so no path through the case leaves rd_data unassigned (no latch).
    always_comb begin
        rd_data = '0;
        case (off)
            REG_CYCLE_LO: rd_data = DATA_W'(cycle_cnt[31:0]);
            REG_CYCLE_HI: rd_data = DATA_W'(hi_shadow);
            REG_TX_STAT:  rd_data = DATA_W'(tx_stat_pack(fifo_full, fifo_empty, ovf,
                                                         4'(fifo_count)));
            REG_SCRATCH:  rd_data = scratch;
            REG_HALT:     rd_data = DATA_W'(exit_code);
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            hi_shadow <= '0;
            scratch   <= '0;
            ovf       <= 1'b0;
            halt      <= 1'b0;
            exit_code <= '0;
            sel_q     <= 1'b0;
            mmio_q    <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            // Reading the low half freezes the high half so a LO/HI pair stays coherent.
            if (rd && mmio_hit && off == REG_CYCLE_LO) hi_shadow <= cycle_cnt[63:32];
            if (rd) begin
                sel_q  <= mmio_hit;
                mmio_q <= rd_data;
            end
            if (wr && off == REG_SCRATCH) scratch <= D_OUT;
            if (push && fifo_full && !pop) ovf <= 1'b1;
            else if (wr && off == REG_TX_STAT && D_OUT[STAT_OVF]) ovf <= 1'b0;
            if (wr && off == REG_HALT && !halt) begin
                halt      <= 1'b1;
                exit_code <= D_OUT[7:0];
            end
        end
    end

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .data  (D_OUT[7:0]),
        .pop   (pop),
        .head  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_dm_mmio_responder.sv
// Bench for dm_mmio_responder: vector table, randomized traffic against a transaction-level
// model, and directed FIFO, counter, halt and reset sequences.
module tb_dm_mmio_responder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] D_ADDR;
    logic [31:0] D_OUT;
    logic        dm_wen;
    logic        dm_oen;
    logic [31:0] D_IN;
    logic [10:0] ram_a;
    logic [31:0] ram_d;
    logic        ram_wen;
    logic        ram_oen;
    logic [31:0] ram_q;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halt;
    logic [7:0]  exit_code;

    dm_mmio_responder dut (
        .clk(clk), .rst_n(rst_n), .D_ADDR(D_ADDR), .D_OUT(D_OUT), .dm_wen(dm_wen),
        .dm_oen(dm_oen), .D_IN(D_IN), .ram_a(ram_a), .ram_d(ram_d), .ram_wen(ram_wen),
        .ram_oen(ram_oen), .ram_q(ram_q), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .halt(halt), .exit_code(exit_code)
    );

    always #5 clk = ~clk;

    // Behaviour of the RAM2Kx32 macro: registered read, old data on same-cycle write.
    logic [31:0] ram_mem [0:2047];
    always @(posedge clk) begin
        if (!ram_oen) ram_q <= ram_mem[ram_a];
        if (!ram_wen) ram_mem[ram_a] <= ram_d;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model state.
    logic [7:0]  m_q[$];
    logic        m_ovf;
    logic [31:0] m_scratch;
    logic        m_halt;
    logic [7:0]  m_exit;
    bit   [31:0] ref_mem [0:2047];

    function automatic logic [31:0] m_stat();
        return {24'd0, 4'(m_q.size()), 1'b0, m_ovf, m_q.size() == 0, m_q.size() == DEPTH};
    endfunction

    function automatic logic [31:0] m_read(input logic [10:0] a);
        if (a[10:4] != 7'h7F) return ref_mem[a];
        case (a[3:0])
            4'd3:    return m_stat();
            4'd4:    return m_scratch;
            4'd5:    return {24'd0, m_exit};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_update(input logic [10:0] a, input logic [31:0] d, input logic w,
                            input logic rdy);
        bit hit, pop, was_full;
        hit      = (a[10:4] == 7'h7F);
        was_full = (m_q.size() == DEPTH);
        pop      = (m_q.size() > 0) && rdy;
        if (pop) void'(m_q.pop_front());
        if (!w && !hit) ref_mem[a] = d;
        if (!w && hit) begin
            case (a[3:0])
                4'd2: if (!was_full || pop) m_q.push_back(d[7:0]); else m_ovf = 1'b1;
                4'd3: if (d[2]) m_ovf = 1'b0;
                4'd4: m_scratch = d;
                4'd5: if (!m_halt) begin m_halt = 1'b1; m_exit = d[7:0]; end
                default: ;
            endcase
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_ovf = 0; m_scratch = 0; m_halt = 0; m_exit = 0;
    endtask

    logic        ram_wen_s, tx_valid_s;
    logic [7:0]  tx_data_s;
    logic [31:0] din_s;

    // One bus cycle: drive at negedge, sample combinational outputs, then D_IN after the edge.
    task automatic cyc(input logic [10:0] a, input logic [31:0] d, input logic w,
                       input logic o, input logic rdy);
        @(negedge clk);
        D_ADDR = a; D_OUT = d; dm_wen = w; dm_oen = o; tx_ready = rdy;
        #1;
        ram_wen_s = ram_wen; tx_valid_s = tx_valid; tx_data_s = tx_data;
        @(posedge clk);
        #1;
        din_s = D_IN;
        dm_wen = 1'b1; dm_oen = 1'b1;
    endtask

    task automatic wr(input logic [10:0] a, input logic [31:0] d);
        cyc(a, d, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic rd(input logic [10:0] a, output logic [31:0] v);
        cyc(a, 32'd0, 1'b1, 1'b0, 1'b0);
        v = din_s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; dm_wen = 1'b1; dm_oen = 1'b1; tx_ready = 1'b0;
        D_ADDR = '0; D_OUT = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    typedef struct {
        logic [10:0] a;
        logic [31:0] d;
        logic        w;
        logic        o;
        logic        chk_din;
        logic [31:0] din;
        logic        rwen;
        string       name;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [31:0] v, lo, hi;

        vecs[0]  = '{11'h7F4, 32'h0,        1, 0, 1, 32'h0,        1, "scratch_reset"};
        vecs[1]  = '{11'h010, 32'hDEADBEEF, 0, 1, 0, 32'h0,        0, "ram_store"};
        vecs[2]  = '{11'h010, 32'h0,        1, 0, 1, 32'hDEADBEEF, 1, "ram_load"};
        vecs[3]  = '{11'h7F4, 32'h55,       0, 1, 0, 32'h0,        1, "mmio_store_shield"};
        vecs[4]  = '{11'h7F4, 32'h0,        1, 0, 1, 32'h55,       1, "scratch_read"};
        vecs[5]  = '{11'h7F4, 32'hA5A5,     0, 0, 1, 32'h55,       1, "rw_same_old"};
        vecs[6]  = '{11'h7F4, 32'h0,        1, 0, 1, 32'hA5A5,     1, "rw_same_new"};
        vecs[7]  = '{11'h7F3, 32'h0,        1, 0, 1, 32'h02,       1, "stat_empty"};
        vecs[8]  = '{11'h7F2, 32'h0,        1, 0, 1, 32'h0,        1, "txdata_read0"};
        vecs[9]  = '{11'h7F5, 32'h0,        1, 0, 1, 32'h0,        1, "halt_read0"};
        vecs[10] = '{11'h7F9, 32'hFFFFFFFF, 0, 1, 0, 32'h0,        1, "unmapped_write"};
        vecs[11] = '{11'h7F9, 32'h0,        1, 0, 1, 32'h0,        1, "unmapped_read"};
        vecs[12] = '{11'h7FF, 32'h0,        1, 0, 1, 32'h0,        1, "top_read"};
        vecs[13] = '{11'h7EF, 32'h12345678, 0, 1, 0, 32'h0,        0, "below_window_store"};
        vecs[14] = '{11'h7EF, 32'h0,        1, 0, 1, 32'h12345678, 1, "below_window_load"};

        do_reset();
        check("reset_tx_valid", tx_valid, 1'b0);
        check("reset_halt", halt, 1'b0);
        check("reset_exit", exit_code, 8'h0);

        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].a, vecs[i].d, vecs[i].w, vecs[i].o, 1'b0);
            check({vecs[i].name, "_ram_wen"}, ram_wen_s, vecs[i].rwen);
            if (vecs[i].chk_din) check(vecs[i].name, din_s, vecs[i].din);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            v = $urandom;
            wr(11'(i), v);
            ref_mem[i] = v;
        end
        for (int i = 0; i < 400; i++) begin
            logic [10:0] a;
            logic [31:0] d, exp_rd;
            logic        w, o, rdy;
            int          kind;
            kind = $urandom_range(0, 9);
            rdy  = ($urandom_range(0, 3) == 0);
            d = $urandom; w = 1'b1; o = 1'b1; a = 11'h000;
            case (kind)
                0, 1: begin a = 11'($urandom_range(0, 31)); w = 1'b0; end
                2, 3: begin a = 11'($urandom_range(0, 31)); o = 1'b0; end
                4:    begin a = 11'h7F4; w = 1'b0; end
                5:    begin a = 11'h7F4; o = 1'b0; w = 1'($urandom_range(0, 1)); end
                6:    begin a = 11'h7F2; w = 1'b0; end
                7:    begin a = 11'h7F3; o = 1'b0; end
                8:    begin a = 11'h7F3; w = 1'b0; end
                default: begin
                    a = {7'h7F, 4'($urandom_range(5, 15))};
                    o = 1'b0;
                    w = (a[3:0] == 4'd5) ? 1'b1 : 1'($urandom_range(0, 1));
                end
            endcase
            exp_rd = m_read(a);
            cyc(a, d, w, o, rdy);
            check("rand_ram_wen", ram_wen_s, w | (a[10:4] == 7'h7F));
            check("rand_tx_valid", tx_valid_s, m_q.size() > 0);
            if (m_q.size() > 0) check("rand_tx_data", tx_data_s, m_q[0]);
            if (!o) check("rand_din", din_s, exp_rd);
            m_update(a, d, w, rdy);
        end

        // FIFO overflow and in-order drain.
        do_reset();
        for (int i = 0; i < 9; i++) wr(11'h7F2, 32'h41 + i);
        rd(11'h7F3, v);
        check("ovf_stat", v, 32'h85);
        for (int i = 0; i < 8; i++) begin
            cyc(11'h000, 32'h0, 1'b1, 1'b1, 1'b1);
            check("drain_valid", tx_valid_s, 1'b1);
            check("drain_data", tx_data_s, 8'(8'h41 + i));
        end
        cyc(11'h000, 32'h0, 1'b1, 1'b1, 1'b1);
        check("drain_empty", tx_valid_s, 1'b0);
        wr(11'h7F3, 32'h4);
        rd(11'h7F3, v);
        check("ovf_cleared", v, 32'h02);

        // Full FIFO with a simultaneous push and pop.
        for (int i = 0; i < 8; i++) wr(11'h7F2, 32'h61 + i);
        cyc(11'h7F2, 32'h5A, 1'b0, 1'b1, 1'b1);
        rd(11'h7F3, v);
        check("full_pushpop_stat", v, 32'h81);
        for (int i = 0; i < 8; i++) begin
            cyc(11'h000, 32'h0, 1'b1, 1'b1, 1'b1);
            check("pushpop_data", tx_data_s, (i == 7) ? 8'h5A : 8'(8'h62 + i));
        end
        cyc(11'h000, 32'h0, 1'b1, 1'b1, 1'b1);
        check("pushpop_empty", tx_valid_s, 1'b0);

        // Push into an empty FIFO with tx_ready high: no bypass that cycle.
        cyc(11'h7F2, 32'h77, 1'b0, 1'b1, 1'b1);
        check("no_bypass", tx_valid_s, 1'b0);
        cyc(11'h000, 32'h0, 1'b1, 1'b1, 1'b0);
        check("enq_valid", tx_valid_s, 1'b1);
        check("enq_data", tx_data_s, 8'h77);

        // Counter carry: LO/HI pair must stay coherent across the 32-bit carry.
        @(negedge clk);
        force dut.cycle_cnt = 64'h0000_0001_FFFF_FFFA;
        #1;
        release dut.cycle_cnt;
        rd(11'h7F0, lo);
        repeat (12) cyc(11'h000, 32'h0, 1'b1, 1'b1, 1'b0);
        rd(11'h7F1, hi);
        check("carry_hi_shadow", hi, 32'h1);
        check("carry_lo_high", lo >= 32'hFFFF_FFF0, 1'b1);
        rd(11'h7F0, lo);
        rd(11'h7F1, hi);
        check("after_carry_hi", hi, 32'h2);
        check("after_carry_lo", lo < 32'h100, 1'b1);

        // Halt is sticky and the first exit code wins.
        check("halt_before", halt, 1'b0);
        wr(11'h7F5, 32'h1234);
        check("halt_set", halt, 1'b1);
        check("exit_code", exit_code, 8'h34);
        wr(11'h7F5, 32'hAB);
        check("exit_code_kept", exit_code, 8'h34);
        rd(11'h7F5, v);
        check("halt_read", v, 32'h34);
        check("halt_still", halt, 1'b1);

        // Reset in the middle of an MMIO read.
        wr(11'h7F2, 32'h99);
        wr(11'h7F4, 32'hCAFE0001);
        rd(11'h7F4, v);
        check("pre_reset_scratch", v, 32'hCAFE0001);
        @(negedge clk);
        D_ADDR = 11'h7F4; dm_oen = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_tx_valid", tx_valid, 1'b0);
        check("midreset_halt", halt, 1'b0);
        check("midreset_exit", exit_code, 8'h0);
        check("midreset_din", D_IN, ram_q);
        @(posedge clk);
        #1;
        check("midreset_din_next", D_IN, ram_q);
        @(negedge clk);
        dm_oen = 1'b1;
        rst_n = 1'b1;
        m_reset();
        rd(11'h7F4, v);
        check("post_reset_scratch", v, 32'h0);
        rd(11'h7F0, lo);
        check("post_reset_lo_small", lo < 32'd16, 1'b1);
        rd(11'h7F1, hi);
        check("post_reset_hi", hi, 32'h0);
        rd(11'h7F3, v);
        check("post_reset_stat", v, 32'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
